// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: state encoding,
// a zero constant and the packed-bus slice helper.
`ifndef REGFILE_MP_PKG_SV
`define REGFILE_MP_PKG_SV

// Port idx of a bus made of equal w-bit fields.
`define RF_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package regfile_mp_pkg;
  localparam int MAX_XLEN = 128;
  localparam logic [MAX_XLEN-1:0] ZERO_XLEN = '0;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;
endpackage

`endif

// File: rtl/regfile_bypass_sel.sv
// Resolves which write port (if any) targets one address; the
// highest-index matching port wins.
module regfile_bypass_sel
  import regfile_mp_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int AW   = 5,
  parameter int NWR  = 1
) (
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [AW-1:0]       addr,
  output logic                hit,
  output logic [XLEN-1:0]     data
);
  always_comb begin
    hit  = 1'b0;
    data = ZERO_XLEN[XLEN-1:0];
    for (int k = 0; k < NWR; k++) begin
      if (wr_en[k] && (`RF_SLICE(wr_addr, k, AW) == addr)) begin
        hit  = 1'b1;
        data = `RF_SLICE(wr_data, k, XLEN);
      end
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, hardwired x0,
// optional post-reset clear sweep and a written-since-reset mask.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int XLEN      = 64,
  parameter  int NREGS     = 32,
  parameter  int NRD       = 2,
  parameter  int NWR       = 1,
  parameter  int BYPASS    = 1,
  parameter  int CLEAR_SEQ = 0,
  localparam int AW        = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*XLEN-1:0]   wr_data,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic                  init_busy,
  output logic [NREGS-1:0]      wr_mask,
  output logic [NREGS*XLEN-1:0] regs_o
);
  rf_state_e                  state_q, state_d;
  logic [AW-1:0]              ptr_q, ptr_d;
  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           mask_q, mask_d;
  logic [NREGS-1:0]           slot_hit;
  logic [NREGS-1:0][XLEN-1:0] slot_data;
  logic                       busy, wr_ok;

  assign busy      = (state_q == RF_CLEAR);
  assign wr_ok     = !rst && !busy;
  assign init_busy = busy;
  assign wr_mask   = mask_q;

  // Per-slot write resolution feeds both the commit logic and the difftest view.
  for (genvar i = 0; i < NREGS; i++) begin : g_slot
    if (i == 0) begin : g_zero
      assign slot_hit[i]  = 1'b0;
      assign slot_data[i] = ZERO_XLEN[XLEN-1:0];
      assign `RF_SLICE(regs_o, i, XLEN) = ZERO_XLEN[XLEN-1:0];
    end else begin : g_reg
      regfile_bypass_sel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_sel (
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .addr   (AW'(i)),
        .hit    (slot_hit[i]),
        .data   (slot_data[i])
      );
      assign `RF_SLICE(regs_o, i, XLEN) = (wr_ok && slot_hit[i]) ? slot_data[i] : regs_q[i];
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            hit;
    logic [XLEN-1:0] byp;

    assign addr = `RF_SLICE(rd_addr, j, AW);

    regfile_bypass_sel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_sel (
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .addr   (addr),
      .hit    (hit),
      .data   (byp)
    );

    assign `RF_SLICE(rd_data, j, XLEN) =
      (rst || busy || !rd_en[j] || (addr == '0)) ? ZERO_XLEN[XLEN-1:0] :
      ((BYPASS != 0) && hit)                     ? byp : regs_q[addr];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    regs_d  = regs_q;
    mask_d  = mask_q;
    if (rst) begin
      mask_d = '0;
      ptr_d  = '0;
      if (CLEAR_SEQ != 0) begin
        state_d = RF_CLEAR;
      end else begin
        state_d = RF_IDLE;
        regs_d  = '0;
      end
    end else if (busy) begin
      regs_d[ptr_q] = ZERO_XLEN[XLEN-1:0];
      ptr_d         = ptr_q + 1'b1;
      if (ptr_q == AW'(NREGS - 1)) state_d = RF_IDLE;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (slot_hit[i]) begin
          regs_d[i] = slot_data[i];
          mask_d[i] = 1'b1;
        end
      end
    end
    regs_d[0] = ZERO_XLEN[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    ptr_q   <= ptr_d;
    regs_q  <= regs_d;
    mask_q  <= mask_d;
  end
endmodule
